// File: rtl/if_id_stage_pkg.sv
// Shared constants and types for the fetch/decode pipeline register:
// bubble encoding, instruction field positions, opcodes and the decoded-field payload.
package if_id_stage_pkg;

  localparam int unsigned XLEN_DEF      = 32;
  localparam int unsigned CNT_W_DEF     = 16;
  localparam int unsigned ILEN          = 32;
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;

  // Field bit positions within a 32-bit RV32I instruction word
  localparam int unsigned OPC_MSB = 6,  OPC_LSB = 0;
  localparam int unsigned RD_MSB  = 11, RD_LSB  = 7;
  localparam int unsigned F3_MSB  = 14, F3_LSB  = 12;
  localparam int unsigned RS1_MSB = 19, RS1_LSB = 15;
  localparam int unsigned RS2_MSB = 24, RS2_LSB = 20;
  localparam int unsigned F7_MSB  = 31, F7_LSB  = 25;

  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OPIMM  = 7'h13;
  localparam logic [6:0] OPC_OP     = 7'h33;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  iimm_shamt;
    logic [11:0] iimm;
    logic [11:0] simm;
    logic [11:0] bimm;
    logic [19:0] uimm;
    logic [19:0] jimm;
  } instr_fields_t;

endpackage

// File: rtl/if_id_stage_if.sv
// Fetch-side inputs and decode-side outputs of the IF/ID pipeline register.
interface if_id_stage_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
);
  logic [XLEN-1:0]  pc_in;
  logic [31:0]      instr_in;
  logic             fetch_valid;
  logic             stall;
  logic             flush;

  logic [XLEN-1:0]  pcD;
  logic [XLEN-1:0]  pc4D;
  logic [31:0]      instrD;
  logic             validD;
  logic [6:0]       opcodeD;
  logic [4:0]       rdD;
  logic [4:0]       rs1D;
  logic [4:0]       rs2D;
  logic [2:0]       funct3D;
  logic [6:0]       funct7D;
  logic [4:0]       iimm_shamtD;
  logic [11:0]      iimmD;
  logic [11:0]      simmD;
  logic [11:0]      bimmD;
  logic [19:0]      uimmD;
  logic [19:0]      jimmD;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output pc_in, instr_in, fetch_valid, stall, flush,
    input  pcD, pc4D, instrD, validD, opcodeD, rdD, rs1D, rs2D, funct3D, funct7D,
           iimm_shamtD, iimmD, simmD, bimmD, uimmD, jimmD, stall_cnt, flush_cnt
  );

  modport slave (
    input  pc_in, instr_in, fetch_valid, stall, flush,
    output pcD, pc4D, instrD, validD, opcodeD, rdD, rs1D, rs2D, funct3D, funct7D,
           iimm_shamtD, iimmD, simmD, bimmD, uimmD, jimmD, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/if_id_stage_fields.sv
// Combinational slicer: instruction word -> register indices, function codes and raw
// immediate fields. Pure wiring, reusable by later stages for debug visibility.
module if_id_fields
  import if_id_stage_pkg::*;
(
  input  logic [ILEN-1:0] instr_i,
  output instr_fields_t   fields_o
);

  always_comb begin
    fields_o            = '0;
    fields_o.opcode     = instr_i[OPC_MSB:OPC_LSB];
    fields_o.rd         = instr_i[RD_MSB:RD_LSB];
    fields_o.rs1        = instr_i[RS1_MSB:RS1_LSB];
    fields_o.rs2        = instr_i[RS2_MSB:RS2_LSB];
    fields_o.funct3     = instr_i[F3_MSB:F3_LSB];
    fields_o.funct7     = instr_i[F7_MSB:F7_LSB];
    fields_o.iimm_shamt = instr_i[RS2_MSB:RS2_LSB];
    fields_o.iimm       = instr_i[31:20];
    fields_o.simm       = {instr_i[31:25], instr_i[11:7]};
    // Branch/jump immediates are scrambled in the encoding; reassemble in offset order
    fields_o.bimm       = {instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8]};
    fields_o.uimm       = instr_i[31:12];
    fields_o.jimm       = {instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21]};
  end

endmodule

// File: rtl/if_id_stage.sv
// IF/ID pipeline register with stall/flush control, decoded field taps and
// saturating stall/flush event counters.
module if_id_stage
  import if_id_stage_pkg::*;
#(
  parameter int unsigned XLEN      = XLEN_DEF,
  parameter int unsigned CNT_W     = CNT_W_DEF,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input logic          clk,
  input logic          rst,
  if_id_stage_if.slave bus
);

  logic [XLEN-1:0]  pc_q, pc_d;
  logic [XLEN-1:0]  pc4_q, pc4_d;
  logic [31:0]      instr_q, instr_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  instr_fields_t    fields;

  // Next-state selection: flush beats stall beats load
  always_comb begin
    pc_d        = pc_q;
    pc4_d       = pc4_q;
    instr_d     = instr_q;
    valid_d     = valid_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;

    if (bus.flush) begin
      pc_d    = '0;
      pc4_d   = XLEN'(4);
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
      if (flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end else if (bus.stall) begin
      if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end else begin
      pc_d    = bus.pc_in;
      pc4_d   = bus.pc_in + XLEN'(4);
      instr_d = bus.fetch_valid ? bus.instr_in : NOP_INSTR;
      valid_d = bus.fetch_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= '0;
      pc4_q       <= XLEN'(4);
      instr_q     <= NOP_INSTR;
      valid_q     <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      pc_q        <= pc_d;
      pc4_q       <= pc4_d;
      instr_q     <= instr_d;
      valid_q     <= valid_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  if_id_fields u_fields (
    .instr_i  (instr_q),
    .fields_o (fields)
  );

  assign bus.pcD         = pc_q;
  assign bus.pc4D        = pc4_q;
  assign bus.instrD      = instr_q;
  assign bus.validD      = valid_q;
  assign bus.stall_cnt   = stall_cnt_q;
  assign bus.flush_cnt   = flush_cnt_q;

  // Field taps come straight off the instruction register, so no input reaches them
  assign bus.opcodeD     = fields.opcode;
  assign bus.rdD         = fields.rd;
  assign bus.rs1D        = fields.rs1;
  assign bus.rs2D        = fields.rs2;
  assign bus.funct3D     = fields.funct3;
  assign bus.funct7D     = fields.funct7;
  assign bus.iimm_shamtD = fields.iimm_shamt;
  assign bus.iimmD       = fields.iimm;
  assign bus.simmD       = fields.simm;
  assign bus.bimmD       = fields.bimm;
  assign bus.uimmD       = fields.uimm;
  assign bus.jimmD       = fields.jimm;

endmodule
